mac_layer_sequencer: RTL and testbench

- Controller that runs one fully-connected layer out of the shared single-port 16-bit CNN RAM.
- Reads FRT_CELL inputs and FRT_CELL*BCK_CELL weights, computes BCK_CELL signed dot products and writes the results back to RAM.
- Arbitrates RAM access between an external host port (when idle) and its own sequencing engine (when busy).
- Sits directly in front of the RAM: drives its data/addr/we and consumes q.

---
 rtl/mac_layer_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mac_layer_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_layer_sequencer.sv
// rtl/mac_layer_sequencer.sv - fully-connected layer engine in front of the shared CNN RAM
module mac_layer_sequencer #(
  parameter int FRT_CELL = 10,
  parameter int BCK_CELL = 5,
  parameter int OUT_BASE = 60,
  parameter int SHIFT    = 0,
  parameter int RELU     = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_data,
  input  logic        host_we,
  output logic        host_wait,
  output logic [15:0] host_q,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_data,
  output logic        ram_we,
  input  logic [15:0] ram_q
);

  localparam int CW = $clog2(FRT_CELL + 1);

  // Result writes must land above every input and weight word.
  if (OUT_BASE < FRT_CELL * (BCK_CELL + 1)) begin : g_cfg_check
    $error("OUT_BASE overlaps the input/weight region");
  end

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WR, FIN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [15:0]        j;
  logic signed [31:0] acc;
  logic [15:0]        x [FRT_CELL];

  // cnt counts issued addresses; the word returning now belongs to cnt-1.
  logic [CW-1:0]      idx;
  logic [15:0]        x_cur;
  logic signed [31:0] prod;
  logic signed [31:0] acc_sh;
  logic [15:0]        result;
  logic [15:0]        eng_addr;
  logic               eng_we;

  assign idx    = cnt - CW'(1);
  assign x_cur  = x[idx];
  assign prod   = $signed({{16{x_cur[15]}}, x_cur}) * $signed({{16{ram_q[15]}}, ram_q});
  assign acc_sh = acc >>> SHIFT;

  // Scale, saturate to 16 bits, then optionally clamp negatives.
  always_comb begin
    if (acc_sh > 32'sd32767) begin
      result = 16'h7fff;
    end else if (acc_sh < -32'sd32768) begin
      result = 16'h8000;
    end else begin
      result = acc_sh[15:0];
    end
    if (RELU != 0 && result[15]) begin
      result = 16'h0000;
    end
  end

  // Engine-side address/write strobe for the current phase.
  always_comb begin
    eng_addr = 16'h0000;
    eng_we   = 1'b0;
    case (state)
      LOAD: eng_addr = 16'(cnt);
      MAC:  eng_addr = 16'(FRT_CELL + FRT_CELL * int'(j) + int'(cnt));
      WR: begin
        eng_addr = 16'(OUT_BASE + int'(j));
        eng_we   = 1'b1;
      end
      default: eng_addr = 16'h0000;
    endcase
  end

  // The host owns the RAM whenever the engine is not running.
  assign ram_addr  = busy ? eng_addr : host_addr;
  assign ram_data  = busy ? result   : host_data;
  assign ram_we    = busy ? eng_we   : host_we;
  assign host_q    = ram_q;
  assign host_wait = busy;

  // Sequencer: load inputs, one MAC pass plus write per output, then a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      j     <= '0;
      acc   <= '0;
      for (int i = 0; i < FRT_CELL; i++) begin
        x[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (cnt != '0) begin
            x[idx] <= ram_q;
          end
          if (cnt == CW'(FRT_CELL)) begin
            state <= MAC;
            cnt   <= '0;
            j     <= '0;
            acc   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        MAC: begin
          if (cnt != '0) begin
            acc <= acc + prod;
          end
          if (cnt == CW'(FRT_CELL)) begin
            state <= WR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WR: begin
          cnt <= '0;
          acc <= '0;
          if (j == 16'(BCK_CELL - 1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            j     <= j + 16'd1;
            state <= MAC;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// tb/tb_mac_layer_sequencer.sv - self-checking bench for mac_layer_sequencer
module tb_mac_layer_sequencer;

  localparam int FRT      = 10;
  localparam int BCK      = 5;
  localparam int OB       = 60;
  localparam int NI       = 3;
  localparam int BUSY_LEN = (FRT + 1) + BCK * (FRT + 2);

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic host_we;
  logic [15:0] host_addr;
  logic [15:0] host_data;

  logic [NI-1:0]       busy_v, done_v, host_wait_v, ram_we_v;
  logic [NI-1:0][15:0] host_q_v, ram_addr_v, ram_data_v;

  always #5 clk = ~clk;

  // Instance 0: defaults; instance 1: RELU=1; instance 2: SHIFT=4. Each has its own RAM.
  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int SH_K = (k == 2) ? 4 : 0;
    localparam int RL_K = (k == 1) ? 1 : 0;
    logic [15:0] mem [256];
    logic [15:0] q;

    mac_layer_sequencer #(
      .FRT_CELL(FRT), .BCK_CELL(BCK), .OUT_BASE(OB), .SHIFT(SH_K), .RELU(RL_K)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .busy(busy_v[k]), .done(done_v[k]),
      .host_addr(host_addr), .host_data(host_data), .host_we(host_we),
      .host_wait(host_wait_v[k]), .host_q(host_q_v[k]),
      .ram_addr(ram_addr_v[k]), .ram_data(ram_data_v[k]), .ram_we(ram_we_v[k]),
      .ram_q(q)
    );

    always @(posedge clk) begin
      if (ram_we_v[k]) mem[ram_addr_v[k][7:0]] <= ram_data_v[k];
      q <= mem[ram_addr_v[k][7:0]];
    end
  end

  int checks;
  int errors;

  logic [15:0] shadow [NI][256];
  bit          init_v [256];
  logic [15:0] exp_out [NI][BCK];
  logic [15:0] q_exp [NI];
  bit          q_ok;
  int          m_n;
  bit          m_done;

  function automatic int sh_of(int k);
    return (k == 2) ? 4 : 0;
  endfunction

  function automatic int rl_of(int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic logic [15:0] model_out(int k, int j);
    int acc, a, b;
    acc = 0;
    for (int i = 0; i < FRT; i++) begin
      a = int'($signed(shadow[k][i]));
      b = int'($signed(shadow[k][FRT + j * FRT + i]));
      acc += a * b;
    end
    acc = acc >>> sh_of(k);
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    if (rl_of(k) != 0 && acc < 0) acc = 0;
    return 16'(acc);
  endfunction

  function automatic logic [15:0] preload(int a);
    if (a < FRT) return 16'(a + 1);
    if (a < OB) return 16'(-250 + 3 * (a - FRT));
    return 16'h0000;
  endfunction

  task automatic chk1(string name, int k, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0b expected=%0b t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic chk16(string name, int k, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0h expected=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic chki(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference timeline: busy cycle n (1..BUSY_LEN) maps to load/MAC/write slots by arithmetic.
  task automatic model_step();
    logic [15:0] ea, ed;
    logic ew;
    bit known, qv;
    int p, qq, j, r;
    if (!reset_n) begin
      m_n    = 0;
      m_done = 0;
    end
    qv = 0;
    for (int k = 0; k < NI; k++) begin
      chk1("busy", k, busy_v[k], m_n != 0);
      chk1("done", k, done_v[k], m_done);
      chk1("host_wait", k, host_wait_v[k], m_n != 0);
      if (q_ok) chk16("host_q", k, host_q_v[k], q_exp[k]);
      known = 1;
      ew    = 1'b0;
      ed    = 16'h0000;
      ea    = 16'h0000;
      if (m_n == 0) begin
        ea = host_addr;
        ew = host_we;
        ed = host_data;
      end else begin
        p = m_n - 1;
        if (p < FRT) ea = 16'(p);
        else if (p == FRT) known = 0;
        else begin
          qq = p - FRT - 1;
          j  = qq / (FRT + 2);
          r  = qq % (FRT + 2);
          if (r < FRT) ea = 16'(FRT + j * FRT + r);
          else if (r == FRT) known = 0;
          else begin
            ea = 16'(OB + j);
            ew = 1'b1;
            ed = exp_out[k][j];
          end
        end
      end
      if (known) chk16("ram_addr", k, ram_addr_v[k], ea);
      chk1("ram_we", k, ram_we_v[k], ew);
      if (ew || m_n == 0) chk16("ram_data", k, ram_data_v[k], ed);
      if (k == 0) qv = known && init_v[ea[7:0]];
      if (known) q_exp[k] = shadow[k][ea[7:0]];
      if (ew) shadow[k][ea[7:0]] = ed;
      if (ew && k == NI - 1) init_v[ea[7:0]] = 1;
    end
    q_ok = qv;
    if (reset_n) begin
      if (m_n == 0) begin
        if (m_done) m_done = 0;
        else if (start) begin
          m_n = 1;
          for (int k = 0; k < NI; k++)
            for (int jj = 0; jj < BCK; jj++) exp_out[k][jj] = model_out(k, jj);
        end
      end else if (m_n == BUSY_LEN) begin
        m_n    = 0;
        m_done = 1;
      end else begin
        m_n++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [15:0] d);
    host_addr = 16'(a);
    host_data = d;
    host_we   = 1'b1;
    tick();
    host_we = 1'b0;
  endtask

  task automatic run_layer(input int ra, input int rb, input int hmode, output int nb, output int nd);
    nb = 0;
    nd = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (busy_v[0]) nb++;
      if (done_v[0]) nd++;
      start = (c == ra || c == rb);
      if (hmode == 1) begin
        host_addr = 16'd70;
        host_data = 16'h1234;
        host_we   = (c <= BUSY_LEN);
        if (c <= BUSY_LEN) chk1("wait_in_run", 0, host_wait_v[0], 1'b1);
      end else begin
        host_we   = 1'($urandom_range(0, 1));
        host_addr = host_we ? 16'($urandom_range(100, 255)) : 16'($urandom_range(0, 255));
        host_data = 16'($urandom);
      end
      tick();
    end
    start   = 1'b0;
    host_we = 1'b0;
  endtask

  initial begin
    int nb, nd, nd2;
    checks    = 0;
    errors    = 0;
    m_n       = 0;
    m_done    = 0;
    q_ok      = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    host_we   = 1'b0;
    host_addr = 16'h00ab;
    host_data = 16'h5a5a;

    repeat (3) tick();
    for (int k = 0; k < NI; k++) begin
      chk1("rst_busy", k, busy_v[k], 1'b0);
      chk1("rst_done", k, done_v[k], 1'b0);
      chk1("rst_we", k, ram_we_v[k], 1'b0);
      chk16("rst_mux_addr", k, ram_addr_v[k], 16'h00ab);
    end
    reset_n = 1'b1;
    tick();

    for (int a = 0; a < 256; a++) host_write(a, preload(a));

    // Reset in busy cycle 30: partial result for output 0 stays, no done pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk1("midrst_busy", k, busy_v[k], 1'b0);
      chk1("midrst_we", k, ram_we_v[k], 1'b0);
    end
    tick();
    tick();
    reset_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (done_v[0]) nd++;
    end
    chki("midrst_no_done", nd, 0);
    chk16("midrst_out0", 0, g_dut[0].mem[60], 16'(-12760));
    chk16("midrst_out1_untouched", 0, g_dut[0].mem[61], 16'h0000);

    // Default data, restarts at cycles 5 and 40 ignored.
    run_layer(5, 40, 0, nb, nd);
    chki("busy_len", nb, 71);
    chki("done_count", nd, 1);
    chk16("out_j0", 0, g_dut[0].mem[60], 16'(-12760));
    chk16("out_j1", 0, g_dut[0].mem[61], 16'(-11110));
    chk16("out_j2", 0, g_dut[0].mem[62], 16'(-9460));
    chk16("out_j3", 0, g_dut[0].mem[63], 16'(-7810));
    chk16("out_j4", 0, g_dut[0].mem[64], 16'(-6160));
    for (int j = 0; j < BCK; j++) chk16("relu_out", 1, g_dut[1].mem[60 + j], 16'h0000);
    chk16("shift4_out0", 2, g_dut[2].mem[60], 16'(-798));

    // Host write while busy is dropped; after done it lands.
    run_layer(0, 0, 1, nb, nd);
    chk16("dropped_write", 0, g_dut[0].mem[70], 16'h0000);
    host_write(70, 16'h1234);
    host_addr = 16'd70;
    tick();
    chk16("host_readback", 0, host_q_v[0], 16'h1234);

    // Saturation both ways.
    for (int a = 0; a < OB; a++) host_write(a, 16'd1000);
    run_layer(0, 0, 0, nb, nd);
    for (int j = 0; j < BCK; j++) begin
      chk16("sat_pos0", 0, g_dut[0].mem[60 + j], 16'h7fff);
      chk16("sat_pos1", 1, g_dut[1].mem[60 + j], 16'h7fff);
      chk16("sat_pos2", 2, g_dut[2].mem[60 + j], 16'h7fff);
    end
    for (int a = FRT; a < OB; a++) host_write(a, 16'(-1000));
    run_layer(0, 0, 0, nb, nd);
    for (int j = 0; j < BCK; j++) begin
      chk16("sat_neg0", 0, g_dut[0].mem[60 + j], 16'h8000);
      chk16("sat_neg1", 1, g_dut[1].mem[60 + j], 16'h0000);
      chk16("sat_neg2", 2, g_dut[2].mem[60 + j], 16'h8000);
    end

    // start in FIN ignored, start in the following IDLE cycle accepted.
    run_layer(72, 73, 0, nb, nd);
    chki("b2b_busy", nb, 78);
    chki("b2b_done", nd, 1);
    nd2 = 0;
    for (int c = 0; c < 80; c++) begin
      if (done_v[0]) nd2++;
      tick();
    end
    chki("b2b_second_done", nd2, 1);

    // Randomised contents and restart pulses, checked cycle by cycle against the model.
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < OB; a++) begin
        if (it % 2 == 0) host_write(a, 16'($urandom));
        else host_write(a, 16'(int'($urandom_range(0, 200)) - 100));
      end
      run_layer(int'($urandom_range(1, 71)), int'($urandom_range(1, 71)), 0, nb, nd);
      chki("rand_busy", nb, 71);
      chki("rand_done", nd, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
